seg_display_ctrl: RTL

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_display_ctrl_hex_to_seg7.sv | 11 +
 rtl/seg_display_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the two-digit seven-segment display controller.
package seg_pkg;

  // Controller phases: wait for a value, convert to BCD, load the display.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  localparam int PWM_BITS_DEF = 4;

  // Segment patterns are active-low, bit order {G,F,E,D,C,B,A}.
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Glyphs 0-9 followed by A, b, C, d, E, F.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Double-dabble correction applied to a BCD digit before each shift.
  function automatic logic [3:0] bcd_add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_hex_to_seg7.sv
// Nibble to active-low seven-segment pattern decoder.
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] i_Nibble,
  output logic [6:0] o_Seg
);

  assign o_Seg = GLYPH_TABLE[i_Nibble];

endmodule

// File: rtl/seg_display_ctrl.sv
// Two-digit seven-segment controller: hex or decimal display of an 8-bit
// value with leading-zero blanking, overflow indication and PWM dimming.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic [7:0]          i_Value,
  input  logic                i_Valid,
  output logic                o_Ready,
  input  logic                i_Mode,
  input  logic                i_Blank_Lz,
  input  logic [PWM_BITS-1:0] i_Bright,
  output logic                o_Segment1_A,
  output logic                o_Segment1_B,
  output logic                o_Segment1_C,
  output logic                o_Segment1_D,
  output logic                o_Segment1_E,
  output logic                o_Segment1_F,
  output logic                o_Segment1_G,
  output logic                o_Segment2_A,
  output logic                o_Segment2_B,
  output logic                o_Segment2_C,
  output logic                o_Segment2_D,
  output logic                o_Segment2_E,
  output logic                o_Segment2_F,
  output logic                o_Segment2_G,
  output logic                o_Overflow
);

  state_t              state_q, state_d;
  logic [7:0]          val_q, val_d;        // captured value / binary shifter
  logic [9:0]          bcd_q, bcd_d;        // {hundreds[1:0], tens, units}
  logic [2:0]          step_q, step_d;
  logic                mode_q, mode_d;
  logic                blank_q, blank_d;    // blanking request of the pending value
  logic [3:0]          dig1_q, dig1_d;
  logic [3:0]          dig2_q, dig2_d;
  logic                dblank_q, dblank_d;  // blanking in effect for the shown value
  logic                shown_q, shown_d;    // something has been loaded since reset
  logic                ovf_q, ovf_d;
  logic                ready_q, ready_d;
  logic [6:0]          seg1_q, seg1_d;
  logic [6:0]          seg2_q, seg2_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;

  logic [3:0] tens_adj, units_adj;
  logic [3:0] dig_nib [2];
  logic [6:0] glyph   [2];
  logic [6:0] pat1, pat2;
  logic       pwm_on;

  assign tens_adj  = bcd_add3(bcd_q[7:4]);
  assign units_adj = bcd_add3(bcd_q[3:0]);

  // One decoder per digit, fed with the digit value about to be displayed so
  // the output register picks up a new load on the same edge.
  assign dig_nib[0] = dig1_d;
  assign dig_nib[1] = dig2_d;
  for (genvar gi = 0; gi < 2; gi++) begin : g_digit
    hex_to_seg7 u_dec (
      .i_Nibble (dig_nib[gi]),
      .o_Seg    (glyph[gi])
    );
  end

  // Next-state logic: handshake capture, BCD conversion and display load.
  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    bcd_d    = bcd_q;
    step_d   = step_q;
    mode_d   = mode_q;
    blank_d  = blank_q;
    dig1_d   = dig1_q;
    dig2_d   = dig2_q;
    dblank_d = dblank_q;
    shown_d  = shown_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (i_Valid && ready_q) begin
          val_d   = i_Value;
          mode_d  = i_Mode;
          blank_d = i_Blank_Lz;
          bcd_d   = '0;
          step_d  = '0;
          state_d = i_Mode ? ST_CONV : ST_LOAD;
        end
      end
      ST_CONV: begin
        bcd_d  = {bcd_q[8], tens_adj, units_adj, val_q[7]};
        val_d  = {val_q[6:0], 1'b0};
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d  = ST_IDLE;
        shown_d  = 1'b1;
        dblank_d = blank_q;
        if (mode_q) begin
          dig1_d = bcd_q[7:4];
          dig2_d = bcd_q[3:0];
          ovf_d  = (bcd_q[9:8] != 2'd0);
        end else begin
          dig1_d = val_q[7:4];
          dig2_d = val_q[3:0];
          ovf_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // Display pattern selection and PWM gating into the output registers.
  always_comb begin
    pat1 = SEG_OFF;
    pat2 = SEG_OFF;
    if (shown_d) begin
      if (ovf_d) begin
        pat1 = SEG_DASH;
        pat2 = SEG_DASH;
      end else begin
        pat1 = (dblank_d && (dig1_d == 4'd0)) ? SEG_OFF : glyph[0];
        pat2 = glyph[1];
      end
    end
    pwm_on = (&i_Bright) || (pwm_q < i_Bright);
    seg1_d = pwm_on ? pat1 : SEG_OFF;
    seg2_d = pwm_on ? pat2 : SEG_OFF;
    pwm_d  = pwm_q + PWM_BITS'(1);
  end

  // State and output registers, cleared immediately when reset asserts.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= ST_IDLE;
      val_q    <= '0;
      bcd_q    <= '0;
      step_q   <= '0;
      mode_q   <= 1'b0;
      blank_q  <= 1'b0;
      dig1_q   <= '0;
      dig2_q   <= '0;
      dblank_q <= 1'b0;
      shown_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b0;
      seg1_q   <= SEG_OFF;
      seg2_q   <= SEG_OFF;
      pwm_q    <= '0;
    end else begin
      state_q  <= state_d;
      val_q    <= val_d;
      bcd_q    <= bcd_d;
      step_q   <= step_d;
      mode_q   <= mode_d;
      blank_q  <= blank_d;
      dig1_q   <= dig1_d;
      dig2_q   <= dig2_d;
      dblank_q <= dblank_d;
      shown_q  <= shown_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
      seg1_q   <= seg1_d;
      seg2_q   <= seg2_d;
      pwm_q    <= pwm_d;
    end
  end

  assign o_Ready      = ready_q;
  assign o_Overflow   = ovf_q;
  assign o_Segment1_A = seg1_q[0];
  assign o_Segment1_B = seg1_q[1];
  assign o_Segment1_C = seg1_q[2];
  assign o_Segment1_D = seg1_q[3];
  assign o_Segment1_E = seg1_q[4];
  assign o_Segment1_F = seg1_q[5];
  assign o_Segment1_G = seg1_q[6];
  assign o_Segment2_A = seg2_q[0];
  assign o_Segment2_B = seg2_q[1];
  assign o_Segment2_C = seg2_q[2];
  assign o_Segment2_D = seg2_q[3];
  assign o_Segment2_E = seg2_q[4];
  assign o_Segment2_F = seg2_q[5];
  assign o_Segment2_G = seg2_q[6];

endmodule
